// File: rtl/cbd_pkg.sv
// Shared constants, FSM state encoding and the centred-binomial coefficient map
// used by the streaming CBD sampler and its per-lane coefficient units.
package cbd_pkg;

    localparam int CBD_Q      = 3329;
    localparam int CBD_COEF_W = 12;
    localparam int CBD_N_COEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Maps the signed difference a-b into [0,q): non-negative results pass
    // through, negative ones wrap to q-(b-a).
    function automatic int unsigned cbd_coef(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned q = CBD_Q);
        int unsigned r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = q - (b - a);
        end
        return r;
    endfunction

endpackage

// File: rtl/cbd_lane.sv
// One sampler lane: turns a 2*ETA-bit field into a coefficient in [0,Q).
// The low ETA bits count positively and the high ETA bits count negatively.
module cbd_lane
    import cbd_pkg::*;
#(
    parameter int ETA    = 2,
    parameter int COEF_W = CBD_COEF_W,
    parameter int Q      = CBD_Q
) (
    input  logic [2*ETA-1:0]  field,
    output logic [COEF_W-1:0] coef
);

    int unsigned pos_cnt;
    int unsigned neg_cnt;

    // Popcount both halves of the field and fold the difference into [0,Q).
    always_comb begin
        pos_cnt = 0;
        neg_cnt = 0;
        for (int i = 0; i < ETA; i++) begin
            pos_cnt = pos_cnt + 32'(field[i]);
            neg_cnt = neg_cnt + 32'(field[ETA+i]);
        end
        coef = COEF_W'(cbd_coef(pos_cnt, neg_cnt, Q));
    end

endmodule

// File: rtl/cbd_stream_sampler.sv
// Streaming centred-binomial sampler. Source words are appended into a bit
// accumulator at the current fill level; whole beats of LANES fields are
// drained from the bottom, converted in parallel and registered onto a
// valid/ready output stream. The accumulator is one beat wider than a source
// word so a word can be appended while a partial beat (ETA=3) is still held.
module cbd_stream_sampler
    import cbd_pkg::*;
#(
    parameter int ETA    = 2,
    parameter int IN_W   = 64,
    parameter int LANES  = 4,
    parameter int COEF_W = CBD_COEF_W,
    parameter int Q      = CBD_Q,
    parameter int N_COEF = CBD_N_COEF,
    parameter int ADDR_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [IN_W-1:0]           in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [LANES*COEF_W-1:0]   out_coef,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int FIELD_W   = 2 * ETA;
    localparam int BEAT_BITS = FIELD_W * LANES;
    localparam int N_WORDS   = N_COEF * FIELD_W / IN_W;
    localparam int N_BEATS   = N_COEF / LANES;
    localparam int BUF_W     = IN_W + BEAT_BITS;
    localparam int CNT_W     = $clog2(BUF_W + 1);
    localparam int WCNT_W    = $clog2(N_WORDS + 1);
    localparam int BCNT_W    = $clog2(N_BEATS + 1);

    localparam logic [CNT_W-1:0]  BEAT_BITS_C = CNT_W'(BEAT_BITS);
    localparam logic [CNT_W-1:0]  IN_W_CNT_C  = CNT_W'(IN_W);
    localparam logic [CNT_W:0]    IN_W_C      = (CNT_W + 1)'(IN_W);
    localparam logic [CNT_W:0]    BUF_W_C     = (CNT_W + 1)'(BUF_W);
    localparam logic [WCNT_W-1:0] N_WORDS_C   = WCNT_W'(N_WORDS);
    localparam logic [BCNT_W-1:0] LAST_BEAT_C = BCNT_W'(N_BEATS - 1);

    if ((ETA != 2) && (ETA != 3)) begin : g_bad_eta
        $error("cbd_stream_sampler: ETA must be 2 or 3");
    end
    if ((N_COEF % LANES) != 0) begin : g_bad_lanes
        $error("cbd_stream_sampler: N_COEF must be a multiple of LANES");
    end
    if (((N_COEF * FIELD_W) % IN_W) != 0) begin : g_bad_words
        $error("cbd_stream_sampler: total field bits must be a multiple of IN_W");
    end

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
    logic [WCNT_W-1:0]         words_q, words_d;
    logic [BCNT_W-1:0]         beats_q, beats_d;
    logic [BUF_W-1:0]          acc_q, acc_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [LANES*COEF_W-1:0]   out_coef_q, out_coef_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      beat_fire;
    logic                      word_fire;
    logic                      beat_accept;
    logic                      in_ready_c;
    logic [CNT_W-1:0]          drained_cnt;
    logic [BUF_W-1:0]          drained_acc;
    logic [BUF_W-1:0]          appended;
    logic [LANES*COEF_W-1:0]   lane_coef;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        cbd_lane #(
            .ETA    (ETA),
            .COEF_W (COEF_W),
            .Q      (Q)
        ) u_lane (
            .field (acc_q[k*FIELD_W +: FIELD_W]),
            .coef  (lane_coef[k*COEF_W +: COEF_W])
        );
    end

    // Handshake decisions: drain first, then decide if a word fits above what remains.
    always_comb begin
        beat_fire   = (state_q == ST_RUN) && (bit_cnt_q >= BEAT_BITS_C) &&
                      (!out_valid_q || out_ready);
        drained_cnt = beat_fire ? (bit_cnt_q - BEAT_BITS_C) : bit_cnt_q;
        drained_acc = beat_fire ? (acc_q >> BEAT_BITS) : acc_q;
        in_ready_c  = (state_q == ST_RUN) && (words_q < N_WORDS_C) &&
                      (({1'b0, drained_cnt} + IN_W_C) <= BUF_W_C);
        word_fire   = in_valid && in_ready_c;
        beat_accept = (state_q == ST_RUN) && out_valid_q && out_ready;
        appended    = word_fire ? (BUF_W'(in_data) << drained_cnt) : '0;
    end

    // Next-state for the control FSM, counters, accumulator and output register.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        words_d     = words_q;
        beats_d     = beats_q;
        acc_d       = acc_q;
        bit_cnt_d   = bit_cnt_q;
        out_coef_d  = out_coef_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                out_coef_d  = '0;
                out_valid_d = 1'b0;
                if (start) begin
                    state_d   = ST_RUN;
                    rd_addr_d = base_addr;
                    words_d   = '0;
                    beats_d   = '0;
                    acc_d     = '0;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_RUN: begin
                acc_d     = drained_acc | appended;
                bit_cnt_d = drained_cnt + (word_fire ? IN_W_CNT_C : '0);
                if (word_fire) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    words_d   = words_q + WCNT_W'(1);
                end
                if (beat_fire) begin
                    out_coef_d  = lane_coef;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (beat_accept) begin
                    beats_d = beats_q + BCNT_W'(1);
                    if (beats_q == LAST_BEAT_C) begin
                        state_d = ST_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_d     = ST_IDLE;
                out_coef_d  = '0;
                out_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset discards any partially sampled polynomial.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            words_q     <= '0;
            beats_q     <= '0;
            acc_q       <= '0;
            bit_cnt_q   <= '0;
            out_coef_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            words_q     <= words_d;
            beats_q     <= beats_d;
            acc_q       <= acc_d;
            bit_cnt_q   <= bit_cnt_d;
            out_coef_q  <= out_coef_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign in_ready  = in_ready_c;
    assign out_coef  = out_coef_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cbd_stream_sampler.sv
// Bench for cbd_stream_sampler: an ETA=2 and an ETA=3 instance share a source
// memory; expected beats are computed from that memory when a polynomial is
// started and compared as the selected instance emits them.
module tb_cbd_stream_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, src_valid, out_ready;
    logic [7:0]  base_addr;
    logic [63:0] mem [256];
    int          sel;

    logic [7:0]  rd_addr2, rd_addr3;
    logic [63:0] in_data2, in_data3;
    logic        in_ready2, in_ready3, out_valid2, out_valid3;
    logic        busy2, busy3, done2, done3, start2, start3;
    logic [47:0] out_coef2, out_coef3;

    logic [7:0]  o_rd_addr;
    logic        o_in_ready, o_valid, o_busy, o_done;
    logic [47:0] o_coef;

    assign start2   = start && (sel == 2);
    assign start3   = start && (sel == 3);
    assign in_data2 = mem[rd_addr2];
    assign in_data3 = mem[rd_addr3];

    assign o_rd_addr  = (sel == 3) ? rd_addr3   : rd_addr2;
    assign o_in_ready = (sel == 3) ? in_ready3  : in_ready2;
    assign o_valid    = (sel == 3) ? out_valid3 : out_valid2;
    assign o_coef     = (sel == 3) ? out_coef3  : out_coef2;
    assign o_busy     = (sel == 3) ? busy3      : busy2;
    assign o_done     = (sel == 3) ? done3      : done2;

    cbd_stream_sampler #(.ETA(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .base_addr(base_addr),
        .rd_addr(rd_addr2), .in_data(in_data2), .in_valid(src_valid),
        .in_ready(in_ready2), .out_coef(out_coef2), .out_valid(out_valid2),
        .out_ready(out_ready), .busy(busy2), .done(done2)
    );

    cbd_stream_sampler #(.ETA(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .base_addr(base_addr),
        .rd_addr(rd_addr3), .in_data(in_data3), .in_valid(src_valid),
        .in_ready(in_ready3), .out_coef(out_coef3), .out_valid(out_valid3),
        .out_ready(out_ready), .busy(busy3), .done(done3)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          vmode, rmode, stall_cnt;
    int          beats_seen, words_seen, done_seen, cur_eta;
    int          total_starts = 0;
    int          total_done = 0;
    logic [7:0]  exp_addr;
    logic [47:0] exp_q [$];
    logic [47:0] captured [64];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference coefficient j of the polynomial whose source starts at base.
    function automatic logic [11:0] model_coef(input int eta, input logic [7:0] base, input int j);
        int         a, b, pos;
        logic [7:0] wa;
        logic       bitv;
        a = 0;
        b = 0;
        for (int t = 0; t < 2 * eta; t++) begin
            pos  = 2 * eta * j + t;
            wa   = base + 8'(pos / 64);
            bitv = mem[wa][pos % 64];
            if (t < eta) a += int'(bitv);
            else         b += int'(bitv);
        end
        return (a >= b) ? 12'(a - b) : 12'(3329 - (b - a));
    endfunction

    // Per-cycle monitor, sampled on the falling edge.
    task automatic checkOutput();
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", {63'd0, o_valid}, 64'd0);
            end else begin
                check("coef", {16'd0, o_coef}, {16'd0, exp_q[0]});
                if (out_ready) begin
                    if (beats_seen < 64) captured[beats_seen] = o_coef;
                    void'(exp_q.pop_front());
                    beats_seen++;
                end
            end
        end
        if (src_valid && o_in_ready) begin
            check("rd_addr", {56'd0, o_rd_addr}, {56'd0, exp_addr});
            exp_addr = exp_addr + 8'd1;
            words_seen++;
        end
        if (o_done) begin
            done_seen++;
            total_done++;
        end
        if (stall_cnt >= 3) check("in_ready_stall", {63'd0, o_in_ready}, 64'd0);
    endtask

    task automatic tick(input logic st);
        @(posedge clk);
        #1;
        start     = st;
        src_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
        if (rmode == 2) stall_cnt++;
        else            stall_cnt = 0;
        @(negedge clk);
        checkOutput();
    endtask

    // Loads the scoreboard for one polynomial and pulses start.
    task automatic applyStimulus(input int eta, input logic [7:0] base);
        logic [47:0] beat;
        sel        = eta;
        cur_eta    = eta;
        base_addr  = base;
        exp_addr   = base;
        beats_seen = 0;
        words_seen = 0;
        done_seen  = 0;
        exp_q.delete();
        for (int bt = 0; bt < 64; bt++) begin
            beat = '0;
            for (int ln = 0; ln < 4; ln++) beat[ln*12 +: 12] = model_coef(eta, base, bt * 4 + ln);
            exp_q.push_back(beat);
        end
        total_starts++;
        tick(1'b1);
        tick(1'b0);
        check("busy_after_start", {63'd0, o_busy}, 64'd1);
    endtask

    task automatic run_until_done(input int budget);
        int cyc;
        cyc = 0;
        while ((done_seen == 0) && (cyc < budget)) begin
            tick(1'b0);
            cyc++;
        end
        check("done_seen", done_seen, 1);
        tick(1'b0);
        check("done_one_cycle", {63'd0, o_done}, 64'd0);
        check("idle_valid", {63'd0, o_valid}, 64'd0);
        check("idle_coef", {16'd0, o_coef}, 64'd0);
        check("idle_busy", {63'd0, o_busy}, 64'd0);
        check("beats", beats_seen, 64);
        check("words", words_seen, 8 * cur_eta);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic random_mem();
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; src_valid = 1'b0; out_ready = 1'b0;
        base_addr = '0; sel = 2; vmode = 0; rmode = 0; stall_cnt = 0;
        beats_seen = 0; words_seen = 0; done_seen = 0; cur_eta = 2; exp_addr = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Reset state on both instances.
        for (int e = 2; e <= 3; e++) begin
            sel = e;
            #1;
            check("rst_rd_addr", {56'd0, o_rd_addr}, 64'd0);
            check("rst_in_ready", {63'd0, o_in_ready}, 64'd0);
            check("rst_valid", {63'd0, o_valid}, 64'd0);
            check("rst_coef", {16'd0, o_coef}, 64'd0);
            check("rst_busy", {63'd0, o_busy}, 64'd0);
            check("rst_done", {63'd0, o_done}, 64'd0);
        end

        // All-zero source, address range wrapping past 255.
        applyStimulus(2, 8'hF8);
        run_until_done(400);

        // Directed nibble patterns in the first word.
        clear_mem();
        mem[8'h20][15:0] = 16'h0C03;
        applyStimulus(2, 8'h20);
        run_until_done(400);
        check("t2_beat0", {16'd0, captured[0]}, {16'd0, 12'd0, 12'd3327, 12'd0, 12'd2});

        // ETA=3: coefficient 10 straddles the ones/zeros word boundary
        // (bits 60..62 set, bit 63 set, bits 64..65 clear) so it is 3-1=2.
        clear_mem();
        mem[8'h30] = '1;
        applyStimulus(3, 8'h30);
        run_until_done(600);
        check("t3_beat0", {16'd0, captured[0]}, 64'd0);
        check("t3_beat1", {16'd0, captured[1]}, 64'd0);
        check("t3_beat2", {16'd0, captured[2]}, {16'd0, 12'd0, 12'd2, 12'd0, 12'd0});

        // Ten-cycle downstream stall in the middle of the stream.
        random_mem();
        applyStimulus(2, 8'h55);
        repeat (20) tick(1'b0);
        rmode = 2;
        repeat (10) tick(1'b0);
        rmode = 0;
        run_until_done(400);

        // A start while running must not disturb the polynomial in flight.
        random_mem();
        applyStimulus(2, 8'h10);
        repeat (10) tick(1'b0);
        base_addr = 8'h99;
        tick(1'b1);
        run_until_done(400);

        // Asynchronous reset mid-polynomial, then a fresh polynomial.
        applyStimulus(3, 8'h40);
        repeat (15) tick(1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        #2;
        check("mid_rst_rd_addr", {56'd0, o_rd_addr}, 64'd0);
        check("mid_rst_valid", {63'd0, o_valid}, 64'd0);
        check("mid_rst_coef", {16'd0, o_coef}, 64'd0);
        check("mid_rst_busy", {63'd0, o_busy}, 64'd0);
        check("mid_rst_in_ready", {63'd0, o_in_ready}, 64'd0);
        @(negedge clk);
        check("mid_rst_done", {63'd0, o_done}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        total_starts--;
        exp_q.delete();
        applyStimulus(3, 8'hFA);
        run_until_done(600);

        // Random source contents, random handshake gaps, both ETA values.
        vmode = 1;
        rmode = 1;
        for (int p = 0; p < 100; p++) begin
            random_mem();
            applyStimulus((p % 2) ? 3 : 2, 8'($urandom_range(0, 255)));
            run_until_done(2000);
        end
        check("done_vs_starts", total_done, total_starts);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
